// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - PS/2 keyboard controller shared constants, types and state helpers
package ps2_kbd_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_REL      = 8'hF0;

    typedef enum logic [2:0] {
        ST_RST_SEND = 3'd0,
        ST_RST_ACK  = 3'd1,
        ST_RST_BAT  = 3'd2,
        ST_IDLE     = 3'd3,
        ST_LED_CMD  = 3'd4,
        ST_LED_ACK1 = 3'd5,
        ST_LED_ARG  = 3'd6,
        ST_LED_ACK2 = 3'd7
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    function automatic logic is_tx_state(input state_e s);
        return (s == ST_RST_SEND) || (s == ST_LED_CMD) || (s == ST_LED_ARG);
    endfunction

    function automatic logic is_led_state(input state_e s);
        return (s == ST_LED_CMD) || (s == ST_LED_ACK1) || (s == ST_LED_ARG) || (s == ST_LED_ACK2);
    endfunction

    // Transmit state -> the state that waits for its acknowledge.
    function automatic state_e ack_of(input state_e s);
        case (s)
            ST_RST_SEND: return ST_RST_ACK;
            ST_LED_CMD:  return ST_LED_ACK1;
            ST_LED_ARG:  return ST_LED_ACK2;
            default:     return s;
        endcase
    endfunction

    // Acknowledge state -> the transmit state that resends its byte.
    function automatic state_e send_of(input state_e s);
        case (s)
            ST_RST_ACK:  return ST_RST_SEND;
            ST_LED_ACK1: return ST_LED_CMD;
            ST_LED_ACK2: return ST_LED_ARG;
            default:     return s;
        endcase
    endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - scancode prefix tracking and one-cycle key event register
module ps2_scan_decoder
    import ps2_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       key_valid,
    output key_event_t key_ev,
    output logic       overrun
);

    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic       valid_q, valid_d;
    key_event_t ev_q, ev_d;

    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        valid_d = 1'b0;
        ev_d    = ev_q;
        overrun = 1'b0;
        if (en && rx_done_tick) begin
            case (rx_data)
                PFX_EXT: ext_d = 1'b1;
                PFX_REL: rel_d = 1'b1;
                8'h00, 8'hFF: begin
                    overrun = 1'b1;
                    ext_d   = 1'b0;
                    rel_d   = 1'b0;
                end
                default: begin
                    valid_d = 1'b1;
                    ev_d    = '{ext: ext_q, rel: rel_q, code: rx_data};
                    ext_d   = 1'b0;
                    rel_d   = 1'b0;
                end
            endcase
        end
        // A byte decoded in the same cycle still emits; only the prefixes are dropped.
        if (clr) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            valid_q <= 1'b0;
            ev_q    <= '0;
        end else begin
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            valid_q <= valid_d;
            ev_q    <= ev_d;
        end
    end

    assign key_valid = valid_q;
    assign key_ev    = ev_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard host controller: init, scancode decode, LED update with retry
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 50_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done_tick,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       led_busy,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_rel,
    output logic       init_done,
    output logic       err
);

    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e          state_q, state_d;
    logic            tx_sent_q, tx_sent_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            rx_en_q, rx_en_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            init_done_q, init_done_d;
    logic            led_pend_q, led_pend_d;
    logic [2:0]      pend_val_q, pend_val_d;
    logic [2:0]      arg_q, arg_d;
    logic            led_busy_q, led_busy_d;

    logic            rx_hit;
    logic            fail;
    logic [7:0]      send_byte;
    logic            ack_tmo;
    logic            dec_overrun;
    logic            dec_valid;
    key_event_t      dec_ev;

    assign rx_hit  = rx_done_tick && rx_en_q;
    assign ack_tmo = (timer_q >= TW'(ACK_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        tx_sent_d   = tx_sent_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        retry_d     = retry_q;
        err_d       = err_q | dec_overrun;
        init_done_d = init_done_q;
        pend_val_d  = led_req ? led_val : pend_val_q;
        led_pend_d  = led_pend_q | led_req;
        arg_d       = arg_q;
        fail        = 1'b0;
        send_byte   = 8'h00;

        case (state_q)
            ST_RST_SEND, ST_LED_CMD, ST_LED_ARG: begin
                if (state_q == ST_RST_SEND)     send_byte = CMD_RESET;
                else if (state_q == ST_LED_CMD) send_byte = CMD_SET_LED;
                else                            send_byte = {5'b0, arg_q};
                if (!tx_sent_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = send_byte;
                    tx_sent_d  = 1'b1;
                    // The LED value is committed when ED first goes out; later requests queue up.
                    if (state_q == ST_LED_CMD && retry_q == '0) begin
                        arg_d      = pend_val_d;
                        led_pend_d = 1'b0;
                    end
                end else if (tx_done_tick) begin
                    state_d = ack_of(state_q);
                end else if (ack_tmo) begin
                    fail = 1'b1;
                end
            end
            ST_RST_ACK, ST_LED_ACK1, ST_LED_ACK2: begin
                if (rx_hit && rx_data == RSP_ACK) begin
                    retry_d = '0;
                    if (state_q == ST_RST_ACK)       state_d = ST_RST_BAT;
                    else if (state_q == ST_LED_ACK1) state_d = ST_LED_ARG;
                    else                             state_d = ST_IDLE;
                end else if ((rx_hit && rx_data == RSP_RESEND) || ack_tmo) begin
                    fail = 1'b1;
                end
            end
            ST_RST_BAT: begin
                if (rx_hit && rx_data == RSP_BAT_OK) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if ((rx_hit && rx_data == RSP_BAT_FAIL) || timer_q >= TW'(BAT_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (led_pend_q) state_d = ST_LED_CMD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            tx_sent_d = 1'b0;
            if (retry_q == RW'(MAX_RETRY)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = send_of(state_q);
            end
        end
        if (state_d != state_q) tx_sent_d = 1'b0;
        if (state_d == ST_IDLE) retry_d = '0;
    end

    // The ACK window is measured from tx_start, so the send->ack hop keeps the timer running.
    always_comb begin
        if (tx_start_d || state_q == ST_IDLE) begin
            timer_d = '0;
        end else if (state_d != state_q &&
                     !(is_tx_state(state_q) && state_d == ack_of(state_q))) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    always_comb begin
        if (tx_start_d) begin
            rx_en_d = 1'b0;
        end else if (tx_done_tick || !is_tx_state(state_d)) begin
            rx_en_d = 1'b1;
        end else begin
            rx_en_d = rx_en_q;
        end
        led_busy_d = led_pend_d | is_led_state(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST_SEND;
            tx_sent_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            rx_en_q     <= 1'b1;
            retry_q     <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
            led_pend_q  <= 1'b0;
            pend_val_q  <= 3'b000;
            arg_q       <= 3'b000;
            led_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sent_q   <= tx_sent_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            rx_en_q     <= rx_en_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
            led_pend_q  <= led_pend_d;
            pend_val_q  <= pend_val_d;
            arg_q       <= arg_d;
            led_busy_q  <= led_busy_d;
        end
    end

    ps2_scan_decoder u_dec (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (state_q == ST_IDLE),
        .clr          (is_tx_state(state_d) && state_d != state_q),
        .rx_done_tick (rx_hit),
        .rx_data      (rx_data),
        .key_valid    (dec_valid),
        .key_ev       (dec_ev),
        .overrun      (dec_overrun)
    );

    assign rx_en     = rx_en_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign led_busy  = led_busy_q;
    assign key_valid = dec_valid;
    assign key_code  = dec_ev.code;
    assign key_ext   = dec_ev.ext;
    assign key_rel   = dec_ev.rel;
    assign init_done = init_done_q;
    assign err       = err_q;

endmodule
